// File: rtl/gerador_pedidos.sv
// Request initiator for the elevator core: debounces the confirm button, validates and queues
// origin/destination pairs, then replays each one on origem/destino/novaEntrada with fixed timing.
module gerador_pedidos #(
  parameter int NUM_ANDARES  = 8,
  parameter int PROFUNDIDADE = 4,
  parameter int T_PULSO      = 2,
  parameter int T_ESPERA     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sw_origem,
  input  logic [3:0] sw_destino,
  input  logic       confirmar,
  output logic [3:0] origem,
  output logic [3:0] destino,
  output logic       novaEntrada,
  output logic       fila_vazia,
  output logic       fila_cheia,
  output logic       erroPedido,
  output logic       pedidoDescartado,
  output logic [1:0] dbEstado
);

  localparam int PW   = $clog2(PROFUNDIDADE);
  localparam int TMAX = (T_PULSO > T_ESPERA) ? T_PULSO : T_ESPERA;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] FIM_PULSO  = TW'(T_PULSO - 1);
  localparam logic [TW-1:0] FIM_ESPERA = TW'(T_ESPERA - 1);
  localparam logic [TW-1:0] TIMER_UM   = TW'(1);
  localparam logic [PW:0]   CNT_CHEIA  = (PW+1)'(PROFUNDIDADE);
  localparam logic [PW:0]   CNT_UM     = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_UM     = PW'(1);
  localparam logic [4:0]    N_ANDARES  = 5'(NUM_ANDARES);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CARREGA = 2'd1,
    PULSO   = 2'd2,
    ESPERA  = 2'd3
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic          vale_q, vale_d, armado_q, armado_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [3:0]    origem_q, origem_d, destino_q, destino_d;
  logic          erro_q, erro_d, desc_q, desc_d;
  logic [7:0]    fila_q [PROFUNDIDADE];

  logic       conf_p, invalido, cheia, vazia, push, pop;
  logic [7:0] cabeca;

  // A button already held through reset must be seen low once before it can request again.
  assign conf_p   = s2_q & ~s3_q & armado_q;
  assign invalido = ({1'b0, sw_origem} >= N_ANDARES) | ({1'b0, sw_destino} >= N_ANDARES) |
                    (sw_origem == sw_destino);
  assign cheia    = (cnt_q == CNT_CHEIA);
  assign vazia    = (cnt_q == '0);
  assign pop      = (estado_q == OCIOSO) & ~vazia;
  assign push     = conf_p & ~invalido & (~cheia | pop);
  assign cabeca   = fila_q[rd_q];

  always_comb begin
    s1_d      = confirmar;
    s2_d      = s1_q;
    s3_d      = s2_q;
    vale_d    = 1'b1;
    armado_d  = armado_q | (vale_q & ~s1_q);
    erro_d    = conf_p & invalido;
    desc_d    = conf_p & ~invalido & cheia & ~pop;
    wr_d      = push ? (wr_q + PTR_UM) : wr_q;
    rd_d      = pop ? (rd_q + PTR_UM) : rd_q;
    origem_d  = pop ? cabeca[7:4] : origem_q;
    destino_d = pop ? cabeca[3:0] : destino_q;
    cnt_d     = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_UM;
      2'b01:   cnt_d = cnt_q - CNT_UM;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    estado_d = estado_q;
    timer_d  = timer_q;
    case (estado_q)
      OCIOSO:  if (pop) estado_d = CARREGA;
      CARREGA: begin
        estado_d = PULSO;
        timer_d  = '0;
      end
      PULSO: begin
        if (timer_q == FIM_PULSO) begin
          estado_d = ESPERA;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + TIMER_UM;
        end
      end
      ESPERA: begin
        if (timer_q == FIM_ESPERA) begin
          estado_d = OCIOSO;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + TIMER_UM;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      timer_q   <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      vale_q    <= 1'b0;
      armado_q  <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      origem_q  <= '0;
      destino_q <= '0;
      erro_q    <= 1'b0;
      desc_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      timer_q   <= timer_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      vale_q    <= vale_d;
      armado_q  <= armado_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      origem_q  <= origem_d;
      destino_q <= destino_d;
      erro_q    <= erro_d;
      desc_q    <= desc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && push) fila_q[wr_q] <= {sw_origem, sw_destino};
  end

  assign origem           = origem_q;
  assign destino          = destino_q;
  assign novaEntrada      = (estado_q == PULSO);
  assign fila_vazia       = vazia;
  assign fila_cheia       = cheia;
  assign erroPedido       = erro_q;
  assign pedidoDescartado = desc_q;
  assign dbEstado         = estado_q;

endmodule

// File: tb/tb_gerador_pedidos.sv
// Bench for gerador_pedidos: directed scenarios plus random presses, every cycle checked
// against a queue-based model of the request flow.
module tb_gerador_pedidos;
  localparam int NA = 8, PROF = 4, TP = 2, TE = 8;

  logic       clock = 1'b0, reset = 1'b0, confirmar = 1'b0;
  logic [3:0] sw_origem = 4'd0, sw_destino = 4'd0;
  logic [3:0] origem, destino;
  logic       novaEntrada, fila_vazia, fila_cheia, erroPedido, pedidoDescartado;
  logic [1:0] dbEstado;

  gerador_pedidos #(.NUM_ANDARES(NA), .PROFUNDIDADE(PROF), .T_PULSO(TP), .T_ESPERA(TE)) dut (
    .clock(clock), .reset(reset), .sw_origem(sw_origem), .sw_destino(sw_destino),
    .confirmar(confirmar), .origem(origem), .destino(destino), .novaEntrada(novaEntrada),
    .fila_vazia(fila_vazia), .fila_cheia(fila_cheia), .erroPedido(erroPedido),
    .pedidoDescartado(pedidoDescartado), .dbEstado(dbEstado));

  always #5 clock = ~clock;

  int total = 0, bad = 0;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs !== esp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  // Reference model: mk counts cycles since a request was loaded (0 = idle), mq is the queue,
  // h1..h3 are the last confirm samples (-1 = not sampled since reset).
  logic [7:0] mq[$];
  int         mk = 0, h1 = -1, h2 = -1, h3 = -1, cyc = 0;
  logic [3:0] m_or = 4'd0, m_de = 4'd0;
  logic       m_erro = 1'b0, m_desc = 1'b0;
  logic       cp, mpop, mcheia, minv;
  int         nk;

  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      mq.delete();
      mk = 0; h1 = -1; h2 = -1; h3 = -1;
      m_or = 4'd0; m_de = 4'd0; m_erro = 1'b0; m_desc = 1'b0;
    end else begin
      cp     = (h2 == 1) && (h3 == 0);
      mpop   = (mk == 0) && (mq.size() > 0);
      mcheia = (mq.size() == PROF);
      minv   = (sw_origem >= NA) || (sw_destino >= NA) || (sw_origem == sw_destino);
      m_erro = cp && minv;
      m_desc = cp && !minv && mcheia && !mpop;
      if (mpop) nk = 1;
      else if (mk == 0 || mk == TP + TE + 1) nk = 0;
      else nk = mk + 1;
      if (mpop) begin
        m_or = mq[0][7:4];
        m_de = mq[0][3:0];
        void'(mq.pop_front());
      end
      if (cp && !minv && (!mcheia || mpop)) mq.push_back({sw_origem, sw_destino});
      mk = nk;
      h3 = h2; h2 = h1; h1 = int'(confirmar);
    end
  end

  logic       chk_en = 1'b0, prev_nova = 1'b0, nova_e;
  logic [1:0] db_e;
  logic [14:0] obs_v, esp_v;
  int         n_erro = 0, n_desc = 0, len_atual = 0, ultimo_len = 0;
  logic [7:0] seen[$];
  int         rise_cyc[$];

  always @(negedge clock) begin
    nova_e = (mk >= 2) && (mk < 2 + TP);
    db_e   = (mk == 0) ? 2'd0 : (mk == 1) ? 2'd1 : nova_e ? 2'd2 : 2'd3;
    obs_v  = {novaEntrada, origem, destino, fila_vazia, fila_cheia, erroPedido,
              pedidoDescartado, dbEstado};
    esp_v  = {nova_e, m_or, m_de, (mq.size() == 0), (mq.size() == PROF), m_erro, m_desc, db_e};
    if (chk_en) verifica("saidas", {17'd0, obs_v}, {17'd0, esp_v});
    if (novaEntrada && !prev_nova) begin
      seen.push_back({origem, destino});
      rise_cyc.push_back(cyc);
      len_atual = 1;
    end else if (novaEntrada) begin
      len_atual++;
    end
    if (!novaEntrada && prev_nova) ultimo_len = len_atual;
    if (erroPedido) n_erro++;
    if (pedidoDescartado) n_desc++;
    prev_nova = novaEntrada;
  end

  task automatic espera(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic aperta(input logic [3:0] o, input logic [3:0] d, input int alto, input int baixo);
    sw_origem = o; sw_destino = d;
    confirmar = 1'b1; espera(alto);
    confirmar = 1'b0; espera(baixo);
  endtask

  int c0, e0, d0, s0, lim;
  logic [7:0] esp4 [7];

  initial begin
    esp4 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h10};
    // reset held with the button pressed
    reset = 1'b0; confirmar = 1'b1; sw_origem = 4'd2; sw_destino = 4'd5;
    @(negedge clock);
    chk_en = 1'b1;
    espera(2);
    verifica("rst_vazia", {31'd0, fila_vazia}, 32'd1);
    verifica("rst_cheia", {31'd0, fila_cheia}, 32'd0);
    verifica("rst_nova", {31'd0, novaEntrada}, 32'd0);
    verifica("rst_estado", {30'd0, dbEstado}, 32'd0);
    verifica("rst_od", {24'd0, origem, destino}, 32'd0);
    reset = 1'b1;
    espera(10);
    confirmar = 1'b0;
    espera(20);
    verifica("sem_pedido_pos_reset", seen.size(), 0);

    // single request
    c0 = cyc;
    aperta(4'd2, 4'd5, 2, 2);
    espera(25);
    verifica("t2_qtd", seen.size(), 1);
    verifica("t2_latencia", rise_cyc[0] - c0, 5);
    verifica("t2_largura", ultimo_len, TP);
    verifica("t2_od", {24'd0, origem, destino}, 32'h25);
    verifica("t2_vazia", {31'd0, fila_vazia}, 32'd1);

    // invalid requests
    e0 = n_erro;
    aperta(4'd3, 4'd3, 2, 2);
    aperta(4'd9, 4'd1, 2, 2);
    espera(10);
    verifica("t3_erros", n_erro - e0, 2);
    verifica("t3_sem_pedido", seen.size(), 1);

    // overflow burst
    s0 = seen.size(); d0 = n_desc;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) aperta(4'd1, 4'd0, 2, 2);
      else aperta(4'd0, 4'(i + 1), 2, 2);
    end
    espera(80);
    verifica("t4_descartes", n_desc - d0, 1);
    verifica("t4_qtd", seen.size() - s0, 7);
    for (int i = 0; i < 7; i++)
      if (s0 + i < seen.size()) verifica("t4_ordem", {24'd0, seen[s0 + i]}, {24'd0, esp4[i]});
    if (s0 + 2 < rise_cyc.size())
      verifica("t4_periodo", rise_cyc[s0 + 2] - rise_cyc[s0 + 1], TP + TE + 2);

    // push coinciding with pop while full
    for (int i = 0; i < 6; i++) aperta(4'd0, 4'(i + 1), 2, 2);
    lim = 0;
    while (!(mk == TP + TE && mq.size() == PROF) && lim < 100) begin
      espera(1);
      lim++;
    end
    verifica("t5_sincronia", {31'd0, (lim < 100)}, 32'd1);
    d0 = n_desc;
    sw_origem = 4'd7; sw_destino = 4'd2;
    confirmar = 1'b1; espera(1);
    confirmar = 1'b0; espera(2);
    verifica("t5_cheia", {31'd0, fila_cheia}, 32'd1);
    espera(90);
    verifica("t5_sem_descarte", n_desc - d0, 0);
    verifica("t5_ultimo", {24'd0, seen[seen.size() - 1]}, 32'h72);
    verifica("t5_vazia", {31'd0, fila_vazia}, 32'd1);

    // reset during the strobe
    aperta(4'd4, 4'd6, 2, 2);
    lim = 0;
    while (!novaEntrada && lim < 30) begin
      espera(1);
      lim++;
    end
    verifica("t6_strobe_visto", {31'd0, novaEntrada}, 32'd1);
    reset = 1'b0;
    espera(1);
    verifica("t6_nova", {31'd0, novaEntrada}, 32'd0);
    verifica("t6_vazia", {31'd0, fila_vazia}, 32'd1);
    verifica("t6_estado", {30'd0, dbEstado}, 32'd0);
    reset = 1'b1;
    s0 = seen.size();
    espera(30);
    verifica("t6_sem_strobe", seen.size(), s0);

    // random presses
    repeat (600) begin
      confirmar = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        sw_origem  = 4'($urandom_range(0, 9));
        sw_destino = 4'($urandom_range(0, 9));
      end
      espera(1);
    end
    confirmar = 1'b0;
    espera(100);
    verifica("final_vazia", {31'd0, fila_vazia}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
